// File: rtl/decode_inst_queue_pkg.sv
// decode_inst_queue_pkg: shared state encodings, PC lane stride and helpers for the IF->ID instruction queue.
package decode_inst_queue_pkg;
  typedef enum logic {IQ_NORMAL, IQ_WAIT_DS} iq_state_e;
  localparam int IQ_PC_STRIDE = 4;
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/decode_inst_queue_storage.sv
// decode_inst_queue_storage: circular buffer of {delayslot, addr, inst} with FETCH_WIDTH write lanes and one read port.
module decode_inst_queue_storage
  import decode_inst_queue_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic [FETCH_WIDTH-1:0]            we_i,
  input  logic [PW-1:0]                     wr_ptr_i,
  input  logic [ADDR_WIDTH-1:0]             wr_addr_i,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] wr_inst_i,
  input  logic                              wr_ds_i,
  input  logic                              set_ds_i,
  input  logic [PW-1:0]                     set_ds_ptr_i,
  input  logic [PW-1:0]                     rd_ptr_i,
  output logic [ADDR_WIDTH-1:0]             rd_addr_o,
  output logic [INST_WIDTH-1:0]             rd_inst_o,
  output logic                              rd_ds_o
);
  logic                  ds_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [PW-1:0]         idx    [FETCH_WIDTH];
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) idx[i] = wr_ptr_i + PW'(i);
  end
  // lane i carries the PC one instruction stride after lane i-1
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (we_i[i]) begin
        ds_q[idx[i]]   <= wr_ds_i;
        addr_q[idx[i]] <= wr_addr_i + ADDR_WIDTH'(IQ_PC_STRIDE * i);
        inst_q[idx[i]] <= wr_inst_i[i*INST_WIDTH +: INST_WIDTH];
      end
    end
    if (set_ds_i) ds_q[set_ds_ptr_i] <= 1'b1;
  end
  assign rd_addr_o = addr_q[rd_ptr_i];
  assign rd_inst_o = inst_q[rd_ptr_i];
  assign rd_ds_o   = ds_q[rd_ptr_i];
endmodule

// File: rtl/decode_inst_queue.sv
// decode_inst_queue: IF->ID instruction queue with MIPS delay-slot tracking and exception flush.
module decode_inst_queue
  import decode_inst_queue_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [FETCH_WIDTH-1:0]            fetch_valid,
  input  logic [ADDR_WIDTH-1:0]             fetch_addr,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] fetch_inst,
  output logic                              fetch_ready,
  output logic                              id_valid,
  input  logic                              id_ready,
  output logic [ADDR_WIDTH-1:0]             id_addr,
  output logic [INST_WIDTH-1:0]             id_inst,
  output logic                              id_delayslot_flag,
  input  logic                              branch_taken
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [CW-1:0]          count_q, count_d, enq_n;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  iq_state_e              state_q, state_d;
  logic [FETCH_WIDTH-1:0] we;
  logic                   wr_ds, set_ds, deq, take, lane0;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [INST_WIDTH-1:0]  rd_inst;
  logic                   rd_ds;
  decode_inst_queue_storage #(
    .ADDR_WIDTH(ADDR_WIDTH), .INST_WIDTH(INST_WIDTH), .DEPTH(DEPTH), .FETCH_WIDTH(FETCH_WIDTH)
  ) u_storage (
    .clk(clk), .we_i(we), .wr_ptr_i(wr_ptr_q), .wr_addr_i(fetch_addr), .wr_inst_i(fetch_inst),
    .wr_ds_i(wr_ds), .set_ds_i(set_ds), .set_ds_ptr_i(rd_ptr_q + PW'(1)), .rd_ptr_i(rd_ptr_q),
    .rd_addr_o(rd_addr), .rd_inst_o(rd_inst), .rd_ds_o(rd_ds)
  );
  assign id_valid          = count_q != '0;
  assign id_addr           = id_valid ? rd_addr : '0;
  assign id_inst           = id_valid ? rd_inst : '0;
  assign id_delayslot_flag = id_valid & rd_ds;
  assign fetch_ready       = (CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH);
  assign enq_n             = fetch_ready ? CW'(popcount4(4'(fetch_valid))) : '0;
  assign deq               = id_valid & id_ready;
  assign take              = deq & branch_taken & (state_q == IQ_NORMAL);
  assign lane0             = fetch_valid[0] & fetch_ready;
  // priority: flush, then taken branch, then delay-slot wait, then plain enqueue/dequeue
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    state_d  = state_q;
    we       = '0;
    wr_ds    = 1'b0;
    set_ds   = 1'b0;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = IQ_NORMAL;
    end else if (take && count_q >= CW'(2)) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      wr_ptr_d = rd_ptr_q + PW'(2);
      count_d  = CW'(1);
      set_ds   = 1'b1;
    end else if (take) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = lane0 ? CW'(1) : '0;
      we       = lane0 ? FETCH_WIDTH'(1) : '0;
      wr_ds    = lane0;
      wr_ptr_d = lane0 ? wr_ptr_q + PW'(1) : wr_ptr_q;
      state_d  = lane0 ? IQ_NORMAL : IQ_WAIT_DS;
    end else if (state_q == IQ_WAIT_DS) begin
      count_d  = lane0 ? count_q + CW'(1) : count_q;
      we       = lane0 ? FETCH_WIDTH'(1) : '0;
      wr_ds    = lane0;
      wr_ptr_d = lane0 ? wr_ptr_q + PW'(1) : wr_ptr_q;
      state_d  = lane0 ? IQ_NORMAL : IQ_WAIT_DS;
    end else begin
      we       = fetch_ready ? fetch_valid : '0;
      wr_ptr_d = wr_ptr_q + PW'(enq_n);
      rd_ptr_d = rd_ptr_q + PW'(deq);
      count_d  = count_q + enq_n - CW'(deq);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      state_q  <= IQ_NORMAL;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      state_q  <= state_d;
    end
  end
  a_ds_branch: assert property (@(posedge clk) disable iff (rst) !(deq && branch_taken && id_delayslot_flag));
  a_contig: assert property (@(posedge clk) disable iff (rst) ((fetch_valid + FETCH_WIDTH'(1)) & fetch_valid) == '0);
endmodule

// File: tb/tb_decode_inst_queue.sv
// tb_decode_inst_queue: directed scenario tests for decode_inst_queue with DEPTH=8, FETCH_WIDTH=2.
module tb_decode_inst_queue;
  import decode_inst_queue_pkg::*;
  logic        clk = 0, rst = 1, flush = 0, id_ready = 0, branch_taken = 0;
  logic [1:0]  fetch_valid = '0;
  logic [31:0] fetch_addr = '0;
  logic [63:0] fetch_inst = '0;
  logic        fetch_ready, id_valid, id_delayslot_flag;
  logic [31:0] id_addr, id_inst;
  int          errors = 0, checks = 0;

  decode_inst_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(8), .FETCH_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .fetch_inst(fetch_inst), .fetch_ready(fetch_ready), .id_valid(id_valid), .id_ready(id_ready),
    .id_addr(id_addr), .id_inst(id_inst), .id_delayslot_flag(id_delayslot_flag), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] v);
    fetch_addr  = a;
    fetch_valid = v;
    fetch_inst  = {32'hC000_0000 | (a + 32'd4), 32'hC000_0000 | a};
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] v);
    drive(a, v);
    cyc;
    fetch_valid = '0;
  endtask

  task automatic test_reset;
    cyc;
    cyc;
    rst = 0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", fetch_ready); end
    checks++; if (id_addr !== 32'h0 || id_inst !== 32'h0 || id_delayslot_flag !== 1'b0) begin errors++; $display("FAIL reset_outs: addr=%h inst=%h ds=%b want 0", id_addr, id_inst, id_delayslot_flag); end
    push(32'h10, 2'b11);
    push(32'h18, 2'b11);
    push(32'h20, 2'b01);
    checks++; if (dut.count_q !== 4'd5) begin errors++; $display("FAIL midstream_count: got %0d want 5", dut.count_q); end
    checks++; if (id_addr !== 32'h10) begin errors++; $display("FAIL midstream_head: got %h want 10", id_addr); end
    rst = 1;
    cyc;
    rst = 0;
    checks++; if (id_valid !== 1'b0 || fetch_ready !== 1'b1 || id_addr !== 32'h0) begin errors++; $display("FAIL midreset: valid=%b ready=%b addr=%h want 0/1/0", id_valid, fetch_ready, id_addr); end
  endtask

  task automatic test_fill;
    for (int g = 0; g < 4; g++) begin
      checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", g, fetch_ready); end
      push(32'h100 + 32'(8 * g), 2'b11);
      checks++; if (id_addr !== 32'h100) begin errors++; $display("FAIL fill_head%0d: got %h want 100", g, id_addr); end
    end
    checks++; if (fetch_ready !== 1'b0 || dut.count_q !== 4'd8) begin errors++; $display("FAIL full: ready=%b count=%0d want 0/8", fetch_ready, dut.count_q); end
    id_ready = 1;
    drive(32'h900, 2'b11);
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL deq_no_ready: got %b want 0", fetch_ready); end
    cyc;
    fetch_valid = '0;
    checks++; if (dut.count_q !== 4'd7 || fetch_ready !== 1'b0) begin errors++; $display("FAIL after_deq: count=%0d ready=%b want 7/0", dut.count_q, fetch_ready); end
    for (int k = 1; k < 8; k++) begin
      checks++; if (id_addr !== 32'h100 + 32'(4 * k) || id_inst !== 32'hC000_0100 + 32'(4 * k)) begin errors++; $display("FAIL drain%0d: addr=%h inst=%h want %h", k, id_addr, id_inst, 32'h100 + 32'(4 * k)); end
      cyc;
    end
    checks++; if (id_valid !== 1'b0 || id_addr !== 32'h0) begin errors++; $display("FAIL drained: valid=%b addr=%h want 0/0", id_valid, id_addr); end
    id_ready = 0;
  endtask

  task automatic test_branch_in_queue;
    push(32'h200, 2'b11);
    push(32'h208, 2'b11);
    id_ready = 1;
    branch_taken = 1;
    drive(32'h210, 2'b11);
    checks++; if (id_addr !== 32'h200 || id_delayslot_flag !== 1'b0) begin errors++; $display("FAIL br_head: addr=%h ds=%b want 200/0", id_addr, id_delayslot_flag); end
    cyc;
    id_ready = 0;
    branch_taken = 0;
    fetch_valid = '0;
    checks++; if (dut.count_q !== 4'd1 || id_addr !== 32'h204 || id_delayslot_flag !== 1'b1 || id_inst !== 32'hC000_0204) begin errors++; $display("FAIL br_ds: count=%0d addr=%h ds=%b want 1/204/1", dut.count_q, id_addr, id_delayslot_flag); end
    push(32'h400, 2'b01);
    id_ready = 1;
    cyc;
    checks++; if (id_addr !== 32'h400 || id_delayslot_flag !== 1'b0 || id_inst !== 32'hC000_0400) begin errors++; $display("FAIL br_target: addr=%h ds=%b want 400/0", id_addr, id_delayslot_flag); end
    cyc;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL br_empty: got %b want 0", id_valid); end
    id_ready = 0;
  endtask

  task automatic test_branch_same_cycle;
    push(32'h300, 2'b01);
    id_ready = 1;
    branch_taken = 1;
    drive(32'h304, 2'b11);
    cyc;
    id_ready = 0;
    branch_taken = 0;
    fetch_valid = '0;
    checks++; if (dut.count_q !== 4'd1 || id_addr !== 32'h304 || id_delayslot_flag !== 1'b1 || id_inst !== 32'hC000_0304) begin errors++; $display("FAIL same_ds: count=%0d addr=%h ds=%b want 1/304/1", dut.count_q, id_addr, id_delayslot_flag); end
    id_ready = 1;
    cyc;
    checks++; if (id_valid !== 1'b0 || dut.count_q !== 4'd0) begin errors++; $display("FAIL same_drop: valid=%b count=%0d want 0/0", id_valid, dut.count_q); end
    id_ready = 0;
  endtask

  task automatic test_wait_ds;
    push(32'h500, 2'b01);
    id_ready = 1;
    branch_taken = 1;
    cyc;
    id_ready = 0;
    branch_taken = 0;
    checks++; if (id_valid !== 1'b0 || dut.state_q !== IQ_WAIT_DS) begin errors++; $display("FAIL wait_enter: valid=%b state=%0d want 0/WAIT_DS", id_valid, dut.state_q); end
    cyc;
    checks++; if (dut.state_q !== IQ_WAIT_DS) begin errors++; $display("FAIL wait_hold: state=%0d want WAIT_DS", dut.state_q); end
    push(32'h504, 2'b11);
    checks++; if (dut.count_q !== 4'd1 || id_addr !== 32'h504 || id_delayslot_flag !== 1'b1 || dut.state_q !== IQ_NORMAL) begin errors++; $display("FAIL wait_ds: count=%0d addr=%h ds=%b state=%0d want 1/504/1/NORMAL", dut.count_q, id_addr, id_delayslot_flag, dut.state_q); end
    id_ready = 1;
    cyc;
    id_ready = 0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL wait_drop: got %b want 0", id_valid); end
    push(32'h700, 2'b11);
    checks++; if (dut.count_q !== 4'd2 || id_addr !== 32'h700 || id_delayslot_flag !== 1'b0) begin errors++; $display("FAIL wait_normal: count=%0d addr=%h ds=%b want 2/700/0", dut.count_q, id_addr, id_delayslot_flag); end
    id_ready = 1;
    cyc;
    checks++; if (id_addr !== 32'h704 || id_inst !== 32'hC000_0704) begin errors++; $display("FAIL wait_lane1: addr=%h inst=%h want 704", id_addr, id_inst); end
    cyc;
    id_ready = 0;
  endtask

  task automatic test_flush;
    push(32'h5F0, 2'b11);
    flush = 1;
    id_ready = 1;
    branch_taken = 1;
    drive(32'h600, 2'b11);
    cyc;
    flush = 0;
    id_ready = 0;
    branch_taken = 0;
    fetch_valid = '0;
    checks++; if (id_valid !== 1'b0 || dut.count_q !== 4'd0 || dut.state_q !== IQ_NORMAL || fetch_ready !== 1'b1) begin errors++; $display("FAIL flush: valid=%b count=%0d state=%0d ready=%b want 0/0/NORMAL/1", id_valid, dut.count_q, dut.state_q, fetch_ready); end
    checks++; if (dut.rd_ptr_q !== 3'd0 || dut.wr_ptr_q !== 3'd0) begin errors++; $display("FAIL flush_ptr: rd=%0d wr=%0d want 0/0", dut.rd_ptr_q, dut.wr_ptr_q); end
    push(32'h610, 2'b01);
    checks++; if (id_addr !== 32'h610 || id_delayslot_flag !== 1'b0 || dut.count_q !== 4'd1) begin errors++; $display("FAIL flush_after: addr=%h ds=%b count=%0d want 610/0/1", id_addr, id_delayslot_flag, dut.count_q); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_branch_in_queue;
    test_branch_same_cycle;
    test_wait_ds;
    test_flush;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
